fmadd_multiplier_stage: RTL and testbench

FMADD_MULTIPLIER_STAGE -- requirements
Module: fmadd_multiplier_stage

---
 rtl/fmadd_multiplier_stage_pkg.sv | 15 +
 rtl/fmadd_multiplier_stage_if.sv | 28 ++
 rtl/fmadd_multiplier_stage.sv | 95 +++++++++
 tb/tb_fmadd_multiplier_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fmadd_multiplier_stage_pkg.sv
// Shared FPU definitions: default operand geometry, exponent bias and the
// multiplier-stage state encoding.
package fmadd_multiplier_stage_pkg;
    localparam int FP_STD = 31;
    localparam int FP_MAN = 22;
    localparam int FP_EXP = 7;

    function automatic int fp_bias(input int e);
        return (1 << e) - 1;
    endfunction

    localparam int FP_BIAS = (1 << FP_EXP) - 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MUL, S_DONE} state_t;
endpackage

// File: rtl/fmadd_multiplier_stage_if.sv
// Request/result bundle between the FMA front end and the multiplier stage.
interface fmadd_multiplier_stage_if
    import fmadd_multiplier_stage_pkg::*;
#(
    parameter int std = FP_STD,
    parameter int man = FP_MAN,
    parameter int exp = FP_EXP
);
    logic             start;
    logic [std+1:0]   a_in;
    logic [std+1:0]   b_in;
    logic             busy;
    logic             done;
    logic             prod_sign;
    logic [exp+2:0]   prod_exp;
    logic [2*man+3:0] prod_mant;
    logic             prod_zero;

    modport master (
        output start, a_in, b_in,
        input  busy, done, prod_sign, prod_exp, prod_mant, prod_zero
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, prod_sign, prod_exp, prod_mant, prod_zero
    );
endinterface

// File: rtl/fmadd_multiplier_stage.sv
// Sequential shift-add significand multiplier for the FMA datapath: one
// multiplier bit per cycle, full-width product, exponent in unbiased-corrected form.
module fmadd_multiplier_stage
    import fmadd_multiplier_stage_pkg::*;
#(
    parameter int std = FP_STD,
    parameter int man = FP_MAN,
    parameter int exp = FP_EXP
)(
    input  logic clk,
    input  logic rst,
    fmadd_multiplier_stage_if.slave bus
);
    localparam int OW = std + 2;
    localparam int EW = exp + 3;
    localparam int PW = 2*man + 4;
    localparam int SW = man + 2;
    localparam int CW = $clog2(man + 2);
    localparam logic [EW-1:0] BIAS    = EW'(fp_bias(exp));
    localparam logic [CW-1:0] CNT_END = CW'(man + 1);

    state_t          state, state_nx;
    logic [OW-1:0]   a_q, b_q;
    logic [PW-1:0]   mcand, acc;
    logic [SW-1:0]   mplier;
    logic [CW-1:0]   cnt;
    logic            sign_q, zero_q;
    logic [EW-1:0]   exp_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus.start) state_nx = S_LOAD;
            S_LOAD: state_nx = S_MUL;
            S_MUL:  if (cnt == CNT_END) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
        endcase
    end

    assign bus.busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q           <= '0;
            b_q           <= '0;
            mcand         <= '0;
            acc           <= '0;
            mplier        <= '0;
            cnt           <= '0;
            sign_q        <= 1'b0;
            zero_q        <= 1'b0;
            exp_q         <= '0;
            bus.done      <= 1'b0;
            bus.prod_sign <= 1'b0;
            bus.prod_exp  <= '0;
            bus.prod_mant <= '0;
            bus.prod_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    a_q <= bus.a_in;
                    b_q <= bus.b_in;
                end
                S_LOAD: begin
                    acc    <= '0;
                    mcand  <= PW'(a_q[SW-1:0]);
                    mplier <= b_q[SW-1:0];
                    cnt    <= '0;
                    sign_q <= a_q[std+1] ^ b_q[std+1];
                    // Exponent fields are unsigned; the wider result is two's complement.
                    exp_q  <= EW'(a_q[std:SW]) + EW'(b_q[std:SW]) - BIAS;
                    zero_q <= (a_q[SW-1:0] == '0) || (b_q[SW-1:0] == '0);
                end
                S_MUL: begin
                    if (mplier[0]) acc <= acc + (mcand << cnt);
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                S_DONE: begin
                    bus.done      <= 1'b1;
                    bus.prod_sign <= sign_q;
                    bus.prod_exp  <= exp_q;
                    bus.prod_mant <= acc;
                    bus.prod_zero <= zero_q;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fmadd_multiplier_stage.sv
// Directed bench for fmadd_multiplier_stage with a cycle-level reference model
// and a per-cycle output comparator.
module tb_fmadd_multiplier_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fmadd_multiplier_stage_if ifc();
    fmadd_multiplier_stage dut (.clk(clk), .rst(rst), .bus(ifc));

    localparam logic [32:0] ONE  = {1'b0, 8'h7F, 1'b1, 23'h0};
    localparam logic [32:0] M2   = {1'b1, 8'h80, 1'b1, 23'h0};
    localparam logic [32:0] P3   = {1'b0, 8'h80, 1'b1, 23'h400000};
    localparam logic [32:0] SUB  = {1'b0, 8'h01, 1'b0, 23'h1};
    localparam logic [32:0] ZERO = 33'h0;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int n_done = 0;
    int obs_done_cyc = -1;
    int done_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference model: timing from accept cycle, results from real arithmetic.
    bit          pend = 0;
    int          due = 0, free_at = 0, done_cyc = -1;
    logic        p_sign, m_sign;
    logic [9:0]  p_exp, m_exp;
    logic [47:0] p_mant, m_mant;
    logic        p_zero, m_zero;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend = 0; free_at = cyc + 1;
            m_sign = 0; m_exp = 0; m_mant = 0; m_zero = 0;
        end else begin
            if (pend && cyc == due) begin
                m_sign = p_sign; m_exp = p_exp; m_mant = p_mant; m_zero = p_zero;
                pend = 0; done_cyc = cyc;
            end
            if (ifc.start && cyc >= free_at) begin
                automatic longint sa = ifc.a_in[23:0];
                automatic longint sb = ifc.b_in[23:0];
                automatic int e = int'(ifc.a_in[31:24]) + int'(ifc.b_in[31:24]) - 127;
                p_sign = ifc.a_in[32] ^ ifc.b_in[32];
                p_mant = 48'(sa * sb);
                p_exp  = e[9:0];
                p_zero = (sa == 0) || (sb == 0);
                pend = 1; due = cyc + 26; free_at = cyc + 27;
            end
        end
    end

    always @(negedge clk) begin
        if (ifc.done === 1'b1) begin
            n_done++; obs_done_cyc = cyc; done_q.push_back(cyc);
        end
        if (cyc >= 1) begin
            chk("done",      64'(ifc.done),      64'(done_cyc == cyc));
            chk("busy",      64'(ifc.busy),      64'(pend));
            chk("prod_sign", 64'(ifc.prod_sign), 64'(m_sign));
            chk("prod_exp",  64'(ifc.prod_exp),  64'(m_exp));
            chk("prod_mant", 64'(ifc.prod_mant), 64'(m_mant));
            chk("prod_zero", 64'(ifc.prod_zero), 64'(m_zero));
        end
    end

    task automatic run_op(input logic [32:0] a, input logic [32:0] b, input string nm);
        int t0;
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.a_in = a; ifc.b_in = b;
        @(posedge clk); #1;
        t0 = cyc; ifc.start = 1'b0;
        repeat (27) @(posedge clk);
        #1;
        chk({nm, "_latency"}, 64'(obs_done_cyc - t0), 64'd26);
    endtask

    initial begin
        int d0;
        rst = 1'b1; ifc.start = 1'b0; ifc.a_in = '0; ifc.b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(ifc.busy), 64'd0);
        chk("rst_done", 64'(ifc.done), 64'd0);
        chk("rst_mant", 64'(ifc.prod_mant), 64'd0);
        chk("rst_exp",  64'(ifc.prod_exp), 64'd0);
        rst = 1'b0;

        run_op(ONE, ONE, "one_x_one");
        chk("one_mant", 64'(ifc.prod_mant), 64'h4000_0000_0000);
        chk("one_exp",  64'(ifc.prod_exp),  64'd127);
        chk("one_sign", 64'(ifc.prod_sign), 64'd0);

        run_op(M2, P3, "m2_x_p3");
        chk("m2p3_mant", 64'(ifc.prod_mant), 64'h6000_0000_0000);
        chk("m2p3_exp",  64'(ifc.prod_exp),  64'd129);
        chk("m2p3_sign", 64'(ifc.prod_sign), 64'd1);

        run_op(SUB, SUB, "sub_x_sub");
        chk("sub_mant", 64'(ifc.prod_mant), 64'd1);
        chk("sub_exp",  64'(ifc.prod_exp),  64'h383);
        chk("sub_zero", 64'(ifc.prod_zero), 64'd0);

        run_op(ZERO, ONE, "zero_x_one");
        chk("zero_zero", 64'(ifc.prod_zero), 64'd1);
        chk("zero_mant", 64'(ifc.prod_mant), 64'd0);

        // Second start while busy must be dropped.
        d0 = n_done;
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.a_in = P3; ifc.b_in = P3;
        @(posedge clk); #1; ifc.start = 1'b0;
        repeat (4) @(posedge clk);
        #1; ifc.start = 1'b1; ifc.a_in = M2; ifc.b_in = M2;
        @(posedge clk); #1; ifc.start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("busy_start_dones", 64'(n_done - d0), 64'd1);
        chk("busy_start_mant",  64'(ifc.prod_mant), 64'h9000_0000_0000);

        // Start held high: one accept per 27 cycles.
        d0 = n_done;
        done_q.delete();
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.a_in = ONE; ifc.b_in = P3;
        repeat (60) @(posedge clk);
        #1; ifc.start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("held_start_dones", 64'(n_done - d0), 64'd3);
        if (done_q.size() >= 2) chk("done_period", 64'(done_q[1] - done_q[0]), 64'd27);
        else chk("done_period_count", 64'(done_q.size()), 64'd2);

        // Reset mid-operation, with a start in the reset cycle.
        d0 = n_done;
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.a_in = M2; ifc.b_in = P3;
        @(posedge clk); #1; ifc.start = 1'b0;
        repeat (9) @(posedge clk);
        #1; rst = 1'b1; ifc.start = 1'b1;
        @(posedge clk); #1; rst = 1'b0; ifc.start = 1'b0;
        chk("abort_busy", 64'(ifc.busy), 64'd0);
        chk("abort_mant", 64'(ifc.prod_mant), 64'd0);
        chk("abort_exp",  64'(ifc.prod_exp), 64'd0);
        chk("abort_sign", 64'(ifc.prod_sign), 64'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_dones", 64'(n_done - d0), 64'd0);

        run_op(ONE, ONE, "after_reset");
        chk("after_reset_mant", 64'(ifc.prod_mant), 64'h4000_0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
